// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Opcode constants, hazard-controller state encoding and
//               opcode class helpers shared by the pipeline control blocks.
// Revision    : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_DWAIT = 2'd1,
        HZ_IWAIT = 2'd2
    } hz_state_t;

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic uses_rs(input logic [5:0] op);
        return !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational ID-stage source decode and EX/MEM dependency
//               comparators producing the data-hazard stall request.
// Revision    : 1.0
// ============================================================================
module hazard_detect
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] ID_RS,
    input  logic [4:0] ID_RT,
    input  logic [4:0] EX_RD,
    input  logic       EX_REGWRITE,
    input  logic       EX_MEMREAD,
    input  logic [4:0] MEM_RD,
    input  logic       MEM_MEMREAD,
    output logic       data_stall
);

    logic w_rs_live;
    logic w_rt_live;
    logic w_branch;
    logic w_ex_hits_used;
    logic w_ex_hits_any;
    logic w_mem_hits_any;
    logic w_hz_ex_load;
    logic w_hz_ex_alu_br;
    logic w_hz_mem_load_br;

    // Register zero never carries a dependency, so it is masked at the source.
    assign w_rs_live = uses_rs(opcode) && (ID_RS != 5'd0);
    assign w_rt_live = uses_rt(opcode) && (ID_RT != 5'd0);
    assign w_branch  = is_branch(opcode);

    assign w_ex_hits_used = (w_rs_live && (EX_RD == ID_RS)) ||
                            (w_rt_live && (EX_RD == ID_RT));
    assign w_ex_hits_any  = (EX_RD != 5'd0) &&
                            ((EX_RD == ID_RS) || (EX_RD == ID_RT));
    assign w_mem_hits_any = (MEM_RD != 5'd0) &&
                            ((MEM_RD == ID_RS) || (MEM_RD == ID_RT));

    assign w_hz_ex_load     = EX_MEMREAD && (EX_RD != 5'd0) && w_ex_hits_used;
    assign w_hz_ex_alu_br   = w_branch && EX_REGWRITE && !EX_MEMREAD && w_ex_hits_any;
    assign w_hz_mem_load_br = w_branch && MEM_MEMREAD && w_mem_hits_any;

    assign data_stall = w_hz_ex_load || w_hz_ex_alu_br || w_hz_mem_load_br;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for the five-stage pipeline with
//               memory-wait FSM and saturating stall statistics.
// Revision    : 1.0
// ============================================================================
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [4:0]       ID_RS,
    input  logic [4:0]       ID_RT,
    input  logic             BR_TAKEN,
    input  logic [4:0]       EX_RD,
    input  logic             EX_REGWRITE,
    input  logic             EX_MEMREAD,
    input  logic [4:0]       MEM_RD,
    input  logic             MEM_MEMREAD,
    input  logic             MEM_MEMWRITE,
    input  logic             DMEM_READY,
    input  logic             IMEM_READY,
    output logic             PC_WRITE,
    output logic             IFID_WRITE,
    output logic             IFID_FLUSH,
    output logic             IDEX_BUBBLE,
    output logic             PIPE_WRITE,
    output logic             DWAIT,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] DWAIT_CNT,
    output logic [CNT_W-1:0] IWAIT_CNT
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    hz_state_t        r_state;
    hz_state_t        w_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_dwait_cnt;
    logic [CNT_W-1:0] r_iwait_cnt;

    logic w_data_stall;
    logic w_freeze;
    logic w_stall_evt;
    logic w_iwait_evt;

    hazard_detect u_hazard_detect (
        .opcode      (opcode),
        .ID_RS       (ID_RS),
        .ID_RT       (ID_RT),
        .EX_RD       (EX_RD),
        .EX_REGWRITE (EX_REGWRITE),
        .EX_MEMREAD  (EX_MEMREAD),
        .MEM_RD      (MEM_RD),
        .MEM_MEMREAD (MEM_MEMREAD),
        .data_stall  (w_data_stall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HZ_RUN;
            r_stall_cnt <= '0;
            r_dwait_cnt <= '0;
            r_iwait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_freeze && (r_dwait_cnt != c_cnt_max))
                r_dwait_cnt <= r_dwait_cnt + c_cnt_one;
            if (w_stall_evt && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            if (w_iwait_evt && (r_iwait_cnt != c_cnt_max))
                r_iwait_cnt <= r_iwait_cnt + c_cnt_one;
        end
    end

    always_comb begin
        w_next      = HZ_RUN;
        w_freeze    = 1'b0;
        w_stall_evt = 1'b0;
        w_iwait_evt = 1'b0;
        PC_WRITE    = 1'b1;
        IFID_WRITE  = 1'b1;
        IFID_FLUSH  = 1'b0;
        IDEX_BUBBLE = 1'b0;
        PIPE_WRITE  = 1'b1;

        // Outside DWAIT an access starts a freeze; inside it, only readiness matters.
        if (r_state == HZ_DWAIT)
            w_freeze = !DMEM_READY;
        else
            w_freeze = (MEM_MEMREAD || MEM_MEMWRITE) && !DMEM_READY;

        if (w_freeze) begin
            PC_WRITE   = 1'b0;
            IFID_WRITE = 1'b0;
            PIPE_WRITE = 1'b0;
            w_next     = HZ_DWAIT;
        end else if (w_data_stall) begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_BUBBLE = 1'b1;
            w_stall_evt = 1'b1;
        end else if (is_branch(opcode) && BR_TAKEN) begin
            // Redirect wins over an outstanding fetch; the old fetch is dropped.
            IFID_FLUSH = 1'b1;
        end else if (!IMEM_READY) begin
            PC_WRITE    = 1'b0;
            IFID_FLUSH  = 1'b1;
            w_iwait_evt = 1'b1;
            w_next      = HZ_IWAIT;
        end

        if (rst) begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            PIPE_WRITE  = 1'b0;
            IFID_FLUSH  = 1'b1;
            IDEX_BUBBLE = 1'b1;
            w_next      = HZ_RUN;
        end
    end

    assign DWAIT     = w_freeze && !rst;
    assign STALL_CNT = r_stall_cnt;
    assign DWAIT_CNT = r_dwait_cnt;
    assign IWAIT_CNT = r_iwait_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Scoreboard bench for pipeline_hazard_ctrl with directed and
//               randomized stimulus against a rule-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;
    import mips_pkg::*;

    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [5:0]    opcode;
    logic [4:0]    id_rs, id_rt, ex_rd, mem_rd;
    logic          br_taken, ex_regwrite, ex_memread;
    logic          mem_memread, mem_memwrite, dmem_ready, imem_ready;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, pipe_write, dwait;
    logic [CW-1:0] stall_cnt, dwait_cnt, iwait_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .ID_RS(id_rs), .ID_RT(id_rt),
        .BR_TAKEN(br_taken), .EX_RD(ex_rd), .EX_REGWRITE(ex_regwrite),
        .EX_MEMREAD(ex_memread), .MEM_RD(mem_rd), .MEM_MEMREAD(mem_memread),
        .MEM_MEMWRITE(mem_memwrite), .DMEM_READY(dmem_ready), .IMEM_READY(imem_ready),
        .PC_WRITE(pc_write), .IFID_WRITE(ifid_write), .IFID_FLUSH(ifid_flush),
        .IDEX_BUBBLE(idex_bubble), .PIPE_WRITE(pipe_write), .DWAIT(dwait),
        .STALL_CNT(stall_cnt), .DWAIT_CNT(dwait_cnt), .IWAIT_CNT(iwait_cnt)
    );

    typedef struct {
        logic [5:0] ctl;   // {PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_BUBBLE, PIPE_WRITE, DWAIT}
        int         s, d, i;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    bit   m_waiting_mem = 0;
    int   m_s = 0, m_d = 0, m_i = 0;

    // Reference: apply the priority rules in plain terms, counters as integers.
    task automatic expect_cycle();
        exp_t e;
        bit   br, rs_u, rt_u, ex_dep, ex_any, mem_any, stall, freeze;
        br      = (opcode == 6'b000100) || (opcode == 6'b000101);
        rs_u    = !(opcode inside {6'b000010, 6'b000011, 6'b001111}) && id_rs != 0;
        rt_u    = (opcode inside {6'b000000, 6'b000100, 6'b000101, 6'b101011}) && id_rt != 0;
        ex_dep  = ex_rd != 0 && ((rs_u && ex_rd == id_rs) || (rt_u && ex_rd == id_rt));
        ex_any  = ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
        mem_any = mem_rd != 0 && (mem_rd == id_rs || mem_rd == id_rt);
        stall   = (ex_memread && ex_dep) || (br && ex_regwrite && !ex_memread && ex_any)
                  || (br && mem_memread && mem_any);
        freeze  = m_waiting_mem ? !dmem_ready : ((mem_memread || mem_memwrite) && !dmem_ready);
        e.s = m_s; e.d = m_d; e.i = m_i;
        if (rst) begin
            e.ctl = 6'b001100;
            m_s = 0; m_d = 0; m_i = 0; m_waiting_mem = 0;
        end else begin
            m_waiting_mem = freeze;
            if (freeze) begin
                e.ctl = 6'b000001;
                m_d = (m_d < MAXC) ? m_d + 1 : m_d;
            end else if (stall) begin
                e.ctl = 6'b000110;
                m_s = (m_s < MAXC) ? m_s + 1 : m_s;
            end else if (br && br_taken) begin
                e.ctl = 6'b111010;
            end else if (!imem_ready) begin
                e.ctl = 6'b011010;
                m_i = (m_i < MAXC) ? m_i + 1 : m_i;
            end else begin
                e.ctl = 6'b110010;
            end
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({pc_write, ifid_write, ifid_flush, idex_bubble, pipe_write, dwait} !== e.ctl) begin
                errors++;
                $display("FAIL ctl t=%0t got %b exp %b", $time,
                         {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_write, dwait}, e.ctl);
            end
            checks++;
            if (stall_cnt !== CW'(e.s) || dwait_cnt !== CW'(e.d) || iwait_cnt !== CW'(e.i)) begin
                errors++;
                $display("FAIL counters t=%0t got s=%0d d=%0d i=%0d exp s=%0d d=%0d i=%0d",
                         $time, stall_cnt, dwait_cnt, iwait_cnt, e.s, e.d, e.i);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        rst = 0; opcode = OP_RTYPE; id_rs = 5'd9; id_rt = 5'd10; br_taken = 0;
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0; mem_rd = 0;
        mem_memread = 0; mem_memwrite = 0; dmem_ready = 1; imem_ready = 1;
    endtask

    initial begin
        rst = 1; opcode = OP_RTYPE; id_rs = 0; id_rt = 0; br_taken = 0;
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0; mem_rd = 0;
        mem_memread = 0; mem_memwrite = 0; dmem_ready = 1; imem_ready = 1;
        @(posedge clk);
        cyc(); rst = 1; expect_cycle();
        // load-use into an ALU op, then the load moves on
        cyc(); ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_rt = 3; expect_cycle();
        cyc(); mem_memread = 1; mem_rd = 3; id_rt = 3; expect_cycle();
        // load feeding a branch: two stall cycles
        cyc(); opcode = OP_BNE; id_rs = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 1; expect_cycle();
        cyc(); opcode = OP_BNE; id_rs = 1; mem_memread = 1; mem_rd = 1; expect_cycle();
        cyc(); opcode = OP_BNE; id_rs = 1; expect_cycle();
        // taken branch beats fetch wait
        cyc(); opcode = OP_BEQ; br_taken = 1; imem_ready = 0; expect_cycle();
        // data-memory miss for 3 cycles with a load-use hazard underneath
        for (int k = 0; k < 3; k++) begin
            cyc(); mem_memread = 1; dmem_ready = 0; ex_memread = 1; ex_rd = 4; id_rs = 4; expect_cycle();
        end
        cyc(); mem_memread = 1; ex_memread = 1; ex_rd = 4; id_rs = 4; expect_cycle();
        // fetch wait for 2 cycles
        for (int k = 0; k < 2; k++) begin
            cyc(); imem_ready = 0; expect_cycle();
        end
        cyc(); expect_cycle();
        // register zero is never a dependency
        cyc(); id_rs = 0; ex_rd = 0; ex_memread = 1; expect_cycle();
        // counter saturation
        for (int k = 0; k < 9; k++) begin
            cyc(); ex_memread = 1; ex_rd = 7; id_rs = 7; expect_cycle();
        end
        // reset in the middle of a data wait
        cyc(); mem_memwrite = 1; dmem_ready = 0; expect_cycle();
        cyc(); dmem_ready = 0; expect_cycle();
        cyc(); rst = 1; dmem_ready = 0; expect_cycle();
        cyc(); dmem_ready = 0; expect_cycle();
        // randomized traffic with small register space for frequent matches
        for (int n = 0; n < 800; n++) begin
            logic [5:0] ops[8];
            ops = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_LUI};
            cyc();
            rst          = ($urandom_range(0, 59) == 0);
            opcode       = ops[$urandom_range(0, 7)];
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            br_taken     = 1'($urandom);
            ex_rd        = 5'($urandom_range(0, 3));
            ex_regwrite  = 1'($urandom);
            ex_memread   = ($urandom_range(0, 3) == 0);
            mem_rd       = 5'($urandom_range(0, 3));
            mem_memread  = ($urandom_range(0, 3) == 0);
            mem_memwrite = ($urandom_range(0, 5) == 0);
            dmem_ready   = ($urandom_range(0, 3) != 0);
            imem_ready   = ($urandom_range(0, 3) != 0);
            expect_cycle();
        end
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush sequencer for the five-stage MIPS pipeline with branch resolution and register forwarding in ID. Each cycle it decides which pipeline registers advance, hold or take a bubble. Inputs are the ID-stage operands, the EX/MEM destination state and the instruction/data memory ready handshakes. It also keeps saturating stall-cycle counters for performance debug.

## Interface
- CNT_W, 16, width of each stall statistics counter
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  opcode of the instruction in ID
- ID_RS, ID_RT  in  5 each  source register fields of the instruction in ID
- BR_TAKEN  in  1  ID-stage comparison result for BEQ/BNE, already using forwarded operands
- EX_RD  in  5  destination register of the instruction in EX
- EX_REGWRITE, EX_MEMREAD  in  1 each  EX-stage instruction writes a register / is a load
- MEM_RD  in  5  destination register of the instruction in MEM
- MEM_MEMREAD, MEM_MEMWRITE  in  1 each  MEM-stage instruction is a load / store
- DMEM_READY  in  1  data memory completes the MEM-stage access this cycle
- IMEM_READY  in  1  instruction memory delivers the fetch this cycle
- PC_WRITE, IFID_WRITE  out  1 each  PC and IF/ID load enables
- IFID_FLUSH  out  1  IF/ID loads a NOP
- IDEX_BUBBLE  out  1  ID/EX loads a NOP (control bits zero)
- PIPE_WRITE  out  1  enable for ID/EX, EX/MEM and MEM/WB
- DWAIT  out  1  controller is in data-memory wait
- STALL_CNT, DWAIT_CNT, IWAIT_CNT  out  CNT_W each  saturating cycle counters

## Operation
- ID source use: RS is used for every opcode except J (000010), JAL (000011) and LUI (001111). RT is used for R-type (000000), BEQ (000100), BNE (000101) and SW (101011). A match requires the register to be nonzero.
- hz_ex_load: EX_MEMREAD, EX_RD ≠ 0, and EX_RD matches a used source.
- hz_ex_alu_br: the ID instruction is BEQ/BNE, EX_REGWRITE, not EX_MEMREAD, and EX_RD matches RS or RT.
- hz_mem_load_br: the ID instruction is BEQ/BNE, MEM_MEMREAD, and MEM_RD matches RS or RT.
- data_stall = hz_ex_load | hz_ex_alu_br | hz_mem_load_br.
  - Re-evaluated every cycle with no counter.
  - A load feeding a branch therefore stalls 2 cycles. A load feeding a non-branch, or an ALU op feeding a branch, stalls 1 cycle.
- FSM states: RUN, DWAIT, IWAIT. The state register resets to RUN.
- Priority, highest first: data-memory wait > data_stall > taken branch > instruction-memory wait.
- RUN / IWAIT outputs:
  - dmem_busy = (MEM_MEMREAD | MEM_MEMWRITE) & !DMEM_READY. When set: all enables 0, no flush/bubble; next state DWAIT.
  - Otherwise, if data_stall: PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1, PIPE_WRITE=1.
  - Otherwise, if opcode is BEQ/BNE and BR_TAKEN: PC_WRITE=1 (target), IFID_FLUSH=1, PIPE_WRITE=1. The pending fetch is abandoned; instruction memory must accept the new address. Next state RUN.
  - Otherwise, if !IMEM_READY: PC_WRITE=0, IFID_FLUSH=1, PIPE_WRITE=1; next state IWAIT.
  - Otherwise all enables 1 and no flush/bubble; next state RUN.
- DWAIT:
  - While !DMEM_READY, all enables are 0 and the whole pipeline is frozen, WB included.
  - On DMEM_READY, outputs follow the RUN rules, excluding dmem_busy, and the next state is chosen as in RUN.
- Counters:
  - STALL_CNT increments on cycles where data_stall takes effect.
  - DWAIT_CNT increments on frozen cycles.
  - IWAIT_CNT increments on fetch-wait cycles.
  - Each counter saturates at all-ones.

## Timing
- Enables, flush and bubble are combinational from inputs and current state (zero latency). They act at the next rising edge.
- State and counters are registered.
- While rst=1:
  - PC_WRITE, IFID_WRITE and PIPE_WRITE are 0.
  - IFID_FLUSH and IDEX_BUBBLE are 1.
  - DWAIT is 0, all counters are 0, and the next state is RUN.
- Reset asserted mid-DWAIT or mid-IWAIT aborts the wait on that edge.
- A miss in MEM coinciding with data_stall is a DWAIT freeze only. data_stall is re-evaluated after release and is not counted in STALL_CNT during the freeze.
- DMEM_READY high in the same cycle as the access means no wait cycle.

## Structure
- Shared package mips_pkg:
  - Opcode constants OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_LUI.
  - State encoding HZ_RUN, HZ_DWAIT, HZ_IWAIT.
- Sub-module hazard_detect: purely combinational source-use decode and the three comparators, producing data_stall. The top level holds the FSM, priority mux and counters.

## Test plan
- Load-use, ALU consumer: EX_MEMREAD=1, EX_RD=3; ID opcode R-type, ID_RT=3 → one cycle with PC_WRITE=0, IDEX_BUBBLE=1, STALL_CNT=1. Then move the load to MEM (no EX hazard) → all enables 1.
- Load-to-branch: BNE with ID_RS=1, load with EX_RD=1 → stall, then the load moves to MEM with MEM_RD=1 → stall again. STALL_CNT=2, then release.
- Taken branch: BEQ, no hazards, BR_TAKEN=1, IMEM_READY=0 → PC_WRITE=1, IFID_FLUSH=1, state RUN, IWAIT_CNT unchanged.
- Data-memory miss: MEM_MEMREAD=1, DMEM_READY=0 for 3 cycles while hz_ex_load is also true → all enables 0, DWAIT=1, DWAIT_CNT=3, STALL_CNT=0. Then DMEM_READY=1 → stall applies.
- Fetch wait: IMEM_READY=0 for 2 cycles → PC_WRITE=0, IFID_FLUSH=1, PIPE_WRITE=1, IWAIT_CNT=2.
- Edge cases:
  - ID_RS=0 with EX_RD=0 and EX_MEMREAD=1 → no stall.
  - CNT_W=2 with 5 stall cycles → STALL_CNT holds at 3.
  - rst during DWAIT → state RUN and counters 0 on the next edge.
